// File: rtl/tristate_bus_arbiter.sv
// tristate_bus_arbiter: round-robin owner select for one shared 3-state bus (in: clk, rst_n, req[N]; out: one-hot en[N], gnt_id, busy, turnaround)
module tristate_bus_arbiter #(
  parameter int N = 4,
  parameter int MAX_HOLD = 16,
  parameter int TA_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         en,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 turnaround
);
  localparam int IW = $clog2(N);
  localparam int HW = MAX_HOLD > 0 ? $clog2(MAX_HOLD + 1) : 1;
  localparam int TW = $clog2(TA_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, GRANT, TURNAROUND} state_t;
  state_t state, state_n;
  logic [N-1:0] en_n;
  logic [IW-1:0] gnt_n, last_owner, last_n, win, k;
  logic [HW-1:0] hold, hold_n;
  logic [TW-1:0] ta_cnt, ta_n;
  logic release_bus, eval;
  always_comb begin
    win = last_owner;
    k = '0;
    for (int i = N; i >= 1; i--) begin
      k = IW'((int'(last_owner) + i) % N);
      if (req[k]) win = k;
    end
  end
  always_comb begin
    state_n = state;
    en_n = en;
    gnt_n = gnt_id;
    last_n = last_owner;
    hold_n = hold;
    ta_n = ta_cnt;
    release_bus = !req[gnt_id] || (MAX_HOLD != 0 && hold == HW'(MAX_HOLD));
    eval = state == IDLE || (state == TURNAROUND && ta_cnt == TW'(TA_CYCLES));
    if (state == GRANT) begin
      state_n = release_bus ? TURNAROUND : GRANT;
      en_n = release_bus ? '0 : en;
      hold_n = release_bus ? '0 : (&hold ? hold : hold + 1'b1);
      ta_n = release_bus ? TW'(1) : '0;
    end else if (!eval) begin
      ta_n = ta_cnt + 1'b1;
    end else begin
      state_n = |req ? GRANT : IDLE;
      en_n = |req ? N'(1) << win : '0;
      gnt_n = |req ? win : gnt_id;
      last_n = |req ? win : last_owner;
      hold_n = |req ? HW'(1) : '0;
      ta_n = '0;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      en <= '0;
      gnt_id <= '0;
      last_owner <= IW'(N - 1);
      hold <= '0;
      ta_cnt <= '0;
    end else begin
      state <= state_n;
      en <= en_n;
      gnt_id <= gnt_n;
      last_owner <= last_n;
      hold <= hold_n;
      ta_cnt <= ta_n;
    end
  end
  assign busy = state == GRANT;
  assign turnaround = state == TURNAROUND;
endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// tb_tristate_bus_arbiter: random request traffic against a cycle-level ownership model
module tb_tristate_bus_arbiter;
  localparam int N = 4;
  localparam int MH = 16;
  localparam int TA = 1;
  logic clk = 0;
  logic rst_n = 0;
  logic [N-1:0] req = '0;
  logic [N-1:0] req2 = '0;
  logic [N-1:0] en, en2;
  logic [1:0] gnt_id, gnt2;
  logic busy, busy2, turnaround, ta2;
  logic unl_on = 0;
  int vectors = 0;
  int miscompares = 0;
  int m_owner, m_held, m_dead, m_last, m_gid;
  always #5 clk = ~clk;
  tristate_bus_arbiter #(.N(N), .MAX_HOLD(MH), .TA_CYCLES(TA)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .en(en), .gnt_id(gnt_id), .busy(busy), .turnaround(turnaround)
  );
  tristate_bus_arbiter #(.N(N), .MAX_HOLD(0), .TA_CYCLES(TA)) u_unl (
    .clk(clk), .rst_n(rst_n), .req(req2), .en(en2), .gnt_id(gnt2), .busy(busy2), .turnaround(ta2)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner = -1;
      m_held = 0;
      m_dead = 0;
      m_last = N - 1;
      m_gid = 0;
    end else if (m_owner >= 0) begin
      if (!req[m_owner] || (MH != 0 && m_held == MH)) begin
        m_owner = -1;
        m_dead = TA;
      end else m_held++;
    end else if (m_dead > 1) m_dead--;
    else begin
      m_dead = 0;
      for (int i = 1; i <= N; i++)
        if (m_owner < 0 && req[(m_last + i) % N]) m_owner = (m_last + i) % N;
      if (m_owner >= 0) begin
        m_last = m_owner;
        m_gid = m_owner;
        m_held = 1;
      end
    end
  end
  task automatic compare();
    logic [N-1:0] e;
    e = m_owner >= 0 ? N'(1) << m_owner : '0;
    chk("en", en, e);
    chk("busy", busy, m_owner >= 0);
    chk("turnaround", turnaround, m_dead > 0);
    chk("gnt_id", gnt_id, m_gid);
    chk("onehot", $countones(en) <= 1, 1);
    if (unl_on) begin
      chk("unl_en", en2, 4'b0100);
      chk("unl_ta", ta2, 0);
    end
  endtask
  task automatic step(input logic [N-1:0] r, input int n);
    repeat (n) begin
      req = r;
      @(negedge clk);
      compare();
    end
  endtask
  initial begin
    req2 = 4'b0100;
    repeat (2) @(negedge clk);
    compare();
    rst_n = 1;
    step(4'b0010, 6);
    step(4'b0000, 3);
    unl_on = 1;
    step(4'b0011, 3);
    step(4'b0010, 4);
    step(4'b0000, 3);
    step(4'b0101, 40);
    step(4'b0000, 3);
    step(4'b1111, 25);
    step(4'b0000, 3);
    repeat (60) step(N'($urandom), $urandom_range(1, 40));
    unl_on = 0;
    step(4'b0001, 3);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    chk("rst_en", en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ta", turnaround, 0);
    chk("rst_gnt", gnt_id, 0);
    @(negedge clk);
    compare();
    rst_n = 1;
    step(4'b1000, 3);
    step(4'b0000, 3);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
